window_3x3: RTL and testbench

// - Builds a 3x3 pixel neighbourhood from a raster-order pixel stream, one pixel per clk when in_valid.
// - Feeds the convolution/filter stages.
// - Fixed latency (2 cycles) lets downstream sync/control signals be matched with a plain delay line.
// - Two line buffers (inferred block RAM) plus a 3x3 register window.
// - Only full interior windows are emitted; border centres are never output.

---
 rtl/window_3x3_if.sv | 29 ++
 rtl/window_3x3.sv | 164 ++++++++++++++++
 tb/tb_window_3x3.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_3x3_if.sv
// Pixel-stream-in / window-out bundle for the 3x3 neighbourhood builder.
// The producer side (master) drives the pixel stream and observes windows.
interface window_3x3_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic                    in_valid;
    logic                    in_sof;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_sof;
    logic [9*DATA_WIDTH-1:0] out_window;
    logic [XW-1:0]           out_x;
    logic [YW-1:0]           out_y;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, out_sof, out_window, out_x, out_y
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, out_sof, out_window, out_x, out_y
    );
endinterface

// File: rtl/window_3x3.sv
// 3x3 sliding window over a raster pixel stream.
// Stage 1 registers the accepted pixel and the two line-buffer reads; stage 2
// shifts the window and publishes it, giving a fixed two-cycle latency.
module window_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    window_3x3_if.slave bus
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int WW = 9 * DATA_WIDTH;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [DATA_WIDTH-1:0] lb0_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb0_rd_q;
    logic [DATA_WIDTH-1:0] lb1_rd_q;

    logic [XW-1:0]         col_q, col_d;
    logic [YW-1:0]         row_q, row_d;
    logic [XW-1:0]         acc_col;
    logic [YW-1:0]         acc_row;

    logic                  s1_valid_q, s1_valid_d;
    logic [XW-1:0]         s1_col_q, s1_col_d;
    logic [YW-1:0]         s1_row_q, s1_row_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    logic [WW-1:0]         win_q, win_d;
    logic [WW-1:0]         win_shift;
    logic [DATA_WIDTH-1:0] new_col [3];

    logic                  out_valid_q, out_valid_d;
    logic                  out_sof_q, out_sof_d;
    logic [WW-1:0]         out_window_q, out_window_d;
    logic [XW-1:0]         out_x_q, out_x_d;
    logic [YW-1:0]         out_y_q, out_y_d;

    // A start-of-frame pixel is placed at (0,0) regardless of the counters.
    assign acc_col = bus.in_sof ? '0 : col_q;
    assign acc_row = bus.in_sof ? '0 : row_q;

    // Previous-row buffer: registered read, then overwrite with the new pixel.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb0_rd_q         <= lb0_mem[acc_col];
            lb0_mem[acc_col] <= bus.in_data;
        end
    end

    // Two-rows-back buffer: refilled one cycle later with what lb0 held.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb1_rd_q <= lb1_mem[acc_col];
        end
        if (s1_valid_q) begin
            lb1_mem[s1_col_q] <= lb0_rd_q;
        end
    end

    // Newest window column, top to bottom: row r-2, row r-1, row r.
    assign new_col[0] = lb1_rd_q;
    assign new_col[1] = lb0_rd_q;
    assign new_col[2] = s1_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shift
            assign win_shift[(3*gi)*DATA_WIDTH   +: DATA_WIDTH] = win_q[(3*gi+1)*DATA_WIDTH +: DATA_WIDTH];
            assign win_shift[(3*gi+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[(3*gi+2)*DATA_WIDTH +: DATA_WIDTH];
            assign win_shift[(3*gi+2)*DATA_WIDTH +: DATA_WIDTH] = new_col[gi];
        end
    endgenerate

    // Next-state: raster counters, stage-1 capture, window shift and emission.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        s1_valid_d   = bus.in_valid;
        s1_col_d     = s1_col_q;
        s1_row_d     = s1_row_q;
        s1_data_d    = s1_data_q;
        win_d        = win_q;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        out_window_d = out_window_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;

        if (bus.in_valid) begin
            s1_col_d  = acc_col;
            s1_row_d  = acc_row;
            s1_data_d = bus.in_data;
            if (acc_col == X_LAST) begin
                col_d = '0;
                row_d = (acc_row == Y_LAST) ? '0 : acc_row + Y_ONE;
            end else begin
                col_d = acc_col + X_ONE;
                row_d = acc_row;
            end
        end

        // Columns 0 and 1 would mix the tail of the previous line into the
        // window, and rows 0 and 1 would expose stale line-buffer data.
        if (s1_valid_q) begin
            win_d = win_shift;
            if (s1_row_q >= Y_TWO && s1_col_q >= X_TWO) begin
                out_valid_d  = 1'b1;
                out_sof_d    = (s1_row_q == Y_TWO) && (s1_col_q == X_TWO);
                out_window_d = win_shift;
                out_x_d      = s1_col_q - X_ONE;
                out_y_d      = s1_row_q - Y_ONE;
            end
        end
    end

    // State registers; reset squashes everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_col_q     <= '0;
            s1_row_q     <= '0;
            s1_data_q    <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_window_q <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            s1_valid_q   <= s1_valid_d;
            s1_col_q     <= s1_col_d;
            s1_row_q     <= s1_row_d;
            s1_data_q    <= s1_data_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_window_q <= out_window_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_window = out_window_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
endmodule

// File: tb/tb_window_3x3.sv
// Bench for window_3x3: a 4x4 instance checked against a pixel-image model
// through a timed scoreboard, and a 640-wide instance checked by formula.
module tb_window_3x3;
    localparam int DW  = 8;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int BW  = 640;
    localparam int BH  = 6;
    localparam int SXW = $clog2(W);
    localparam int SYW = $clog2(H);
    localparam int BXW = $clog2(BW);
    localparam int BYW = $clog2(BH);
    localparam logic [9*DW-1:0] FIRST_WIN = 72'h222120121110020100;

    typedef struct {
        logic [SXW-1:0]  x;
        logic [SYW-1:0]  y;
        logic            sof;
        logic [9*DW-1:0] win;
        longint          cyc;
    } exp_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    longint cyc   = 0;

    exp_t            sb[$];
    int              n_tests  = 0;
    int              n_fail   = 0;
    int              win_cnt  = 0;
    logic [9*DW-1:0] sof_win  = '0;
    int              mr       = 0;
    int              mc       = 0;
    logic [DW-1:0]   img [H][W];
    int              bwin_cnt = 0;
    int              blast_x  = 0;
    int              blast_y  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_3x3_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W),  .IMG_HEIGHT(H))  s_if ();
    window_3x3_if #(.DATA_WIDTH(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) b_if ();

    window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    function automatic logic [DW-1:0] bpix(input int r, input int c);
        return DW'((r * 37 + c * 3) & 255);
    endfunction

    // Drive one pixel into the small instance and queue its expected window.
    task automatic send(input logic [DW-1:0] v, input bit sof);
        exp_t e;
        @(negedge clk);
        s_if.in_valid = 1'b1;
        s_if.in_sof   = sof;
        s_if.in_data  = v;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            e.x   = SXW'(mc - 1);
            e.y   = SYW'(mr - 1);
            e.sof = (mr == 2 && mc == 2);
            e.cyc = cyc + 2;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(3*i+j)*DW +: DW] = img[mr-2+i][mc-2+j];
            sb.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_if.in_valid = 1'b0;
            s_if.in_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input int off, input bit with_sof, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gaps) idle(int'($urandom_range(0, 1)));
                send(DW'(16 * r + c + off), with_sof && r == 0 && c == 0);
            end
    endtask

    // Small-instance monitor: every out_valid must match the queue head,
    // including the cycle it was due.
    task automatic mon_small();
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_if.out_valid === 1'b1) begin
                win_cnt++;
                if (s_if.out_sof === 1'b1) sof_win = s_if.out_window;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_window: got out_valid=1 x=%0d y=%0d at cyc %0d, required out_valid=0",
                             s_if.out_x, s_if.out_y, cyc);
                end else begin
                    e = sb.pop_front();
                    if (s_if.out_x !== e.x || s_if.out_y !== e.y || s_if.out_sof !== e.sof ||
                        s_if.out_window !== e.win || cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL window: got x=%0d y=%0d sof=%0b win=%h cyc=%0d, required x=%0d y=%0d sof=%0b win=%h cyc=%0d",
                                 s_if.out_x, s_if.out_y, s_if.out_sof, s_if.out_window, cyc,
                                 e.x, e.y, e.sof, e.win, e.cyc);
                    end
                end
            end
        end
    endtask

    // Wide-instance monitor: windows must arrive in raster order with taps
    // matching the pixel formula.
    task automatic mon_big();
        int              bx = 1;
        int              by = 1;
        logic [9*DW-1:0] ew;
        forever begin
            @(negedge clk);
            if (b_if.out_valid === 1'b1) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[(3*i+j)*DW +: DW] = bpix(by - 1 + i, bx - 1 + j);
                n_tests++;
                if (b_if.out_x !== BXW'(bx) || b_if.out_y !== BYW'(by) ||
                    b_if.out_sof !== (bx == 1 && by == 1) || b_if.out_window !== ew) begin
                    n_fail++;
                    $display("FAIL wide_window: got x=%0d y=%0d sof=%0b win=%h, required x=%0d y=%0d win=%h",
                             b_if.out_x, b_if.out_y, b_if.out_sof, b_if.out_window, bx, by, ew);
                end
                bwin_cnt++;
                blast_x = int'(b_if.out_x);
                blast_y = int'(b_if.out_y);
                bx++;
                if (bx == BW - 1) begin
                    bx = 1;
                    by++;
                    if (by == BH - 1) by = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        idle(3);
        n_tests++;
        if (s_if.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", s_if.out_valid);
        end
        n_tests++;
        if (s_if.out_sof !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_sof: got %0b, required 0", s_if.out_sof);
        end
        n_tests++;
        if (s_if.out_x !== '0 || s_if.out_y !== '0) begin
            n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d, required 0 0", s_if.out_x, s_if.out_y);
        end
        n_tests++;
        if (s_if.out_window !== '0) begin
            n_fail++; $display("FAIL reset_window: got %h, required 0", s_if.out_window);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_frame();
        int c0 = win_cnt;
        send_frame(0, 1'b1, 1'b0);
        idle(4);
        n_tests++;
        if (win_cnt - c0 != 4) begin
            n_fail++; $display("FAIL frame_count: got %0d windows, required 4", win_cnt - c0);
        end
        n_tests++;
        if (sof_win !== FIRST_WIN) begin
            n_fail++; $display("FAIL frame_first_taps: got %h, required %h", sof_win, FIRST_WIN);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL frame_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_gaps();
        int c0 = win_cnt;
        send_frame(0, 1'b1, 1'b1);
        idle(4);
        n_tests++;
        if (win_cnt - c0 != 4 || sb.size() != 0) begin
            n_fail++; $display("FAIL gaps_count: got %0d windows %0d pending, required 4 0", win_cnt - c0, sb.size());
        end
        n_tests++;
        if (sof_win !== FIRST_WIN) begin
            n_fail++; $display("FAIL gaps_first_taps: got %h, required %h", sof_win, FIRST_WIN);
        end
    endtask

    task automatic test_back_to_back();
        int c0 = win_cnt;
        send_frame(0, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        idle(4);
        n_tests++;
        if (win_cnt - c0 != 8 || sb.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d windows %0d pending, required 8 0", win_cnt - c0, sb.size());
        end
        n_tests++;
        if (sof_win[DW-1:0] !== 8'h80) begin
            n_fail++; $display("FAIL b2b_second_tap0: got %h, required 80", sof_win[DW-1:0]);
        end
    endtask

    task automatic test_wrap();
        int c0 = win_cnt;
        send_frame(0, 1'b1, 1'b0);
        send_frame(8'h40, 1'b0, 1'b0);
        idle(4);
        n_tests++;
        if (win_cnt - c0 != 8 || sb.size() != 0) begin
            n_fail++; $display("FAIL wrap_count: got %0d windows %0d pending, required 8 0", win_cnt - c0, sb.size());
        end
        n_tests++;
        if (sof_win[DW-1:0] !== 8'h40) begin
            n_fail++; $display("FAIL wrap_second_tap0: got %h, required 40", sof_win[DW-1:0]);
        end
    endtask

    task automatic test_sof_abort();
        int c0 = win_cnt;
        for (int k = 0; k < 9; k++) send(DW'(8'hC0 + k), k == 0);
        send_frame(0, 1'b1, 1'b0);
        idle(4);
        n_tests++;
        if (win_cnt - c0 != 4 || sb.size() != 0) begin
            n_fail++; $display("FAIL abort_count: got %0d windows %0d pending, required 4 0", win_cnt - c0, sb.size());
        end
        n_tests++;
        if (sof_win !== FIRST_WIN) begin
            n_fail++; $display("FAIL abort_first_taps: got %h, required %h", sof_win, FIRST_WIN);
        end
    endtask

    task automatic test_reset_mid();
        int c0 = win_cnt;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c <= 2) send(DW'(16 * r + 3 * c + 5), r == 0 && c == 0);
        @(negedge clk);
        s_if.in_valid = 1'b0;
        s_if.in_sof   = 1'b0;
        reset         = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (s_if.out_valid !== 1'b0 || s_if.out_sof !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_valid: got valid=%0b sof=%0b, required 0 0", s_if.out_valid, s_if.out_sof);
        end
        n_tests++;
        if (s_if.out_x !== '0 || s_if.out_y !== '0 || s_if.out_window !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got x=%0d y=%0d win=%h, required 0 0 0",
                               s_if.out_x, s_if.out_y, s_if.out_window);
        end
        @(negedge clk);
        n_tests++;
        if (s_if.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_squash: got out_valid=%0b, required 0", s_if.out_valid);
        end
        mr = 0;
        mc = 0;
        send_frame(0, 1'b1, 1'b0);
        idle(4);
        n_tests++;
        if (win_cnt - c0 != 4 || sb.size() != 0) begin
            n_fail++; $display("FAIL rstmid_count: got %0d windows %0d pending, required 4 0", win_cnt - c0, sb.size());
        end
        n_tests++;
        if (sof_win !== FIRST_WIN) begin
            n_fail++; $display("FAIL rstmid_first_taps: got %h, required %h", sof_win, FIRST_WIN);
        end
    endtask

    // Full 640-pixel lines with a short frame height.
    task automatic test_full_width();
        int c0 = bwin_cnt;
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++) begin
                @(negedge clk);
                b_if.in_valid = 1'b1;
                b_if.in_sof   = (r == 0 && c == 0);
                b_if.in_data  = bpix(r, c);
            end
        @(negedge clk);
        b_if.in_valid = 1'b0;
        b_if.in_sof   = 1'b0;
        idle(4);
        n_tests++;
        if (bwin_cnt - c0 != (BW - 2) * (BH - 2)) begin
            n_fail++; $display("FAIL wide_count: got %0d windows, required %0d", bwin_cnt - c0, (BW - 2) * (BH - 2));
        end
        n_tests++;
        if (blast_x != BW - 2 || blast_y != BH - 2) begin
            n_fail++; $display("FAIL wide_last_centre: got (%0d,%0d), required (%0d,%0d)", blast_x, blast_y, BW - 2, BH - 2);
        end
    endtask

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_sof   = 1'b0;
        s_if.in_data  = '0;
        b_if.in_valid = 1'b0;
        b_if.in_sof   = 1'b0;
        b_if.in_data  = '0;
        fork
            mon_small();
            mon_big();
        join_none
        test_reset();
        test_frame();
        test_gaps();
        test_back_to_back();
        test_wrap();
        test_sof_abort();
        test_reset_mid();
        test_full_width();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
